vdiv_sched: RTL and testbench
=============================

Name: vdiv_sched

Overview:
- Scheduler that shares one vector integer divide/remainder unit among NREQ vector issue requesters.
- Accepts one vector divide request at a time, round-robin between requesters.
- Latches the request configuration, pulses the unit's start, and tracks the unit's busy signal until the whole vector has drained.
- Reports completion with requester id and destination tag; sits between the issue stage and the divide unit in the vector unit.

Parameters:
- NREQ, 4, number of requesters (>=2).
- DATA_WIDTH, 32, element/scalar operand width.
- MVL, 16, maximum vector length; VLW = clog2(MVL) (1 if MVL<=1) is the vector-length field width.
- TAGW, 5, destination register tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit set
- req_op_div  in  NREQ  per-requester 1=remainder, 0=quotient
- req_cont_esc  in  2*NREQ  per-requester scalar-operand select: 0x=vector-vector, 10=scalar op1, 11=scalar op2
- req_op_esc  in  DATA_WIDTH*NREQ  per-requester scalar operand
- req_mask  in  MVL*NREQ  per-requester element mask
- req_vlr  in  VLW*NREQ  per-requester last element index (unit processes vlr+1 elements)
- req_tag  in  TAGW*NREQ  per-requester destination tag
- du_start  out  1  start pulse to divide unit
- du_op_div  out  1  latched op select
- du_cont_esc  out  2  latched operand select
- du_op_esc  out  DATA_WIDTH  latched scalar operand
- du_mask  out  MVL  latched mask
- du_vlr  out  VLW  latched vlr
- du_busy  in  1  divide unit busy
- done_valid  out  1  one-cycle completion pulse
- done_id  out  clog2(NREQ)  requester that completed
- done_tag  out  TAGW  tag of completed request
- sched_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, rr pointer 0, req_ready=0, du_start=0, all du_* and done_* outputs 0, sched_busy=0.
- States:
  - IDLE: req_ready one-hot to the round-robin winner among valid requesters, searching from the pointer upward with wrap. req_ready is combinational from req_valid and the pointer, and is 0 when no request is valid.
  - IDLE handshake: valid&ready in the same cycle latches that requester's fields and id; pointer becomes winner+1 mod NREQ; next state ISSUE.
  - ISSUE: du_start=1 for exactly this cycle, with du_* already holding the latched values; next state RUN.
  - RUN: stay while du_busy=1; on du_busy=0 go to DONE. The unit raises busy at the edge that samples start, so RUN is entered with busy=1.
  - DONE: done_valid=1 with done_id/done_tag for one cycle. This also covers the unit's one-cycle registered output, so the last element is valid in DONE. Next state IDLE.
- No request accepted outside IDLE; req_ready=0 in ISSUE/RUN/DONE.
- Latency: accept in cycle C0 → du_start in C0+1 → done_valid in C0+vlr+4 → next accept possible in C0+vlr+5.
- vlr=0: one element processed; done at C0+4.
- du_* outputs hold their values until the next accept. They are never changed while du_busy=1.
- done_valid has no back-pressure.
- Simultaneous valids: only the winner is served; losers keep valid asserted and must not change their fields while waiting.
- A requester dropping valid before ready is legal; no transfer occurs.
- Reset mid-operation (any state): immediate return to IDLE next cycle, no done pulse, pointer 0. The divide unit is reset by the same rst.

Optional Feature:
- VDIV_SCHED_PERF_EN defined: adds 32-bit counters perf_ops (+1 per done pulse) and perf_busy_cycles (+1 every cycle sched_busy=1). Counters wrap at 2^32, are cleared by rst, and drive output ports perf_ops/perf_busy_cycles.
- Undefined: perf ports present but tied 0, with no counter logic.

Decomposition:
- Package vdiv_pkg: state enum (IDLE, ISSUE, RUN, DONE), clog2/VLW width function, cont_esc encoding constants.
- Sub-module vdiv_rr_arb: NREQ-wide round-robin arbiter (req, pointer in → one-hot grant, encoded id out).

Test Plan:
- Single request: req0 valid, vlr=3, op_div=0, tag=7 → accept C0, du_start C1 only, done_valid C7 with id=0, tag=7.
- Contention: req0..req3 valid simultaneously, each vlr=0 → served in order 0,1,2,3, one every 5 cycles; then req0 again, re-asserted, served after req3.
- Wrap fairness: pointer=3, req0 and req3 valid → req3 granted first, then req0.
- Config forwarding: req2 cont_esc=2'b11, op_esc=0x10, mask=0xA5A5 → du_* show these values from C1 and hold them through DONE.
- Reset in RUN: vlr=15, assert rst at C5 → IDLE next cycle, no done_valid, req_ready resumes from pointer 0.
- Perf (VDIV_SCHED_PERF_EN): two requests with vlr=3 → perf_ops=2, perf_busy_cycles=14.

Source files
------------

// File: rtl/vdiv_pkg.sv
// rtl/vdiv_pkg.sv - scheduler state encoding, width helper and operand-select codes for the vector divide scheduler
package vdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } vdiv_state_t;

  // cont_esc: 0x vector-vector (bit 0 ignored), 10 scalar op1, 11 scalar op2
  localparam logic [1:0] CONT_VV  = 2'b00;
  localparam logic [1:0] CONT_SC1 = 2'b10;
  localparam logic [1:0] CONT_SC2 = 2'b11;

  function automatic int vdiv_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vdiv_rr_arb.sv
// rtl/vdiv_rr_arb.sv - round-robin arbiter: one-hot grant to the first request at or above ptr, wrapping
module vdiv_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid
);

  int   idx;
  logic hit;

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = 0;
    hit         = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      hit = |((req >> idx) & NREQ'(1));
      if (!grant_valid && hit) begin
        grant_valid = 1'b1;
        grant_id    = IDW'(idx);
        grant       = NREQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/vdiv_sched.sv
// rtl/vdiv_sched.sv - shares one vector divide unit among NREQ issuers; perf counters under VDIV_SCHED_PERF_EN
module vdiv_sched
  import vdiv_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MVL        = 16,
  parameter  int TAGW       = 5,
  localparam int VLW        = vdiv_clog2(MVL),
  localparam int IDW        = vdiv_clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_op_div,
  input  logic [2*NREQ-1:0]      req_cont_esc,
  input  logic [DATA_WIDTH*NREQ-1:0] req_op_esc,
  input  logic [MVL*NREQ-1:0]    req_mask,
  input  logic [VLW*NREQ-1:0]    req_vlr,
  input  logic [TAGW*NREQ-1:0]   req_tag,
  output logic                   du_start,
  output logic                   du_op_div,
  output logic [1:0]             du_cont_esc,
  output logic [DATA_WIDTH-1:0]  du_op_esc,
  output logic [MVL-1:0]         du_mask,
  output logic [VLW-1:0]         du_vlr,
  input  logic                   du_busy,
  output logic                   done_valid,
  output logic [IDW-1:0]         done_id,
  output logic [TAGW-1:0]        done_tag,
  output logic                   sched_busy,
  output logic [31:0]            perf_ops,
  output logic [31:0]            perf_busy_cycles
);

  vdiv_state_t     state, state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_valid;
  logic            accept;
  logic [IDW-1:0]  lat_id;
  logic [TAGW-1:0] lat_tag;

  vdiv_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    accept     = 1'b0;
    du_start   = 1'b0;
    done_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        accept    = grant_valid;
        if (grant_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        du_start  = 1'b1;
        state_nxt = RUN;
      end
      // the unit raised busy on the edge that sampled start, so busy is already high here
      RUN: if (!du_busy) state_nxt = DONE;
      DONE: begin
        done_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lat_id      <= '0;
      lat_tag     <= '0;
      du_op_div   <= 1'b0;
      du_cont_esc <= '0;
      du_op_esc   <= '0;
      du_mask     <= '0;
      du_vlr      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_id      <= grant_id;
        lat_tag     <= req_tag[int'(grant_id)*TAGW +: TAGW];
        rr_ptr      <= (int'(grant_id) == NREQ-1) ? '0 : grant_id + 1'b1;
        du_op_div   <= req_op_div[grant_id];
        du_cont_esc <= req_cont_esc[int'(grant_id)*2 +: 2];
        du_op_esc   <= req_op_esc[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        du_mask     <= req_mask[int'(grant_id)*MVL +: MVL];
        du_vlr      <= req_vlr[int'(grant_id)*VLW +: VLW];
      end
    end
  end

  assign done_id    = done_valid ? lat_id  : '0;
  assign done_tag   = done_valid ? lat_tag : '0;
  assign sched_busy = (state != IDLE);

`ifdef VDIV_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops         <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (done_valid) perf_ops         <= perf_ops + 32'd1;
      if (sched_busy) perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`else
  assign perf_ops         = '0;
  assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_vdiv_sched.sv
// tb/tb_vdiv_sched.sv - self-checking bench for vdiv_sched; perf expectations follow VDIV_SCHED_PERF_EN
module tb_vdiv_sched;
  import vdiv_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int MVL  = 16;
  localparam int TAGW = 5;
  localparam int VLW  = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready, req_op_div;
  logic [2*NREQ-1:0]    req_cont_esc;
  logic [DW*NREQ-1:0]   req_op_esc;
  logic [MVL*NREQ-1:0]  req_mask;
  logic [VLW*NREQ-1:0]  req_vlr;
  logic [TAGW*NREQ-1:0] req_tag;
  logic                 du_start, du_op_div, du_busy;
  logic [1:0]           du_cont_esc;
  logic [DW-1:0]        du_op_esc;
  logic [MVL-1:0]       du_mask;
  logic [VLW-1:0]       du_vlr;
  logic                 done_valid, sched_busy;
  logic [IDW-1:0]       done_id;
  logic [TAGW-1:0]      done_tag;
  logic [31:0]          perf_ops, perf_busy_cycles;

  always #5 clk = ~clk;

  vdiv_sched #(
    .NREQ(NREQ), .DATA_WIDTH(DW), .MVL(MVL), .TAGW(TAGW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op_div(req_op_div),
    .req_cont_esc(req_cont_esc), .req_op_esc(req_op_esc), .req_mask(req_mask),
    .req_vlr(req_vlr), .req_tag(req_tag),
    .du_start(du_start), .du_op_div(du_op_div), .du_cont_esc(du_cont_esc),
    .du_op_esc(du_op_esc), .du_mask(du_mask), .du_vlr(du_vlr), .du_busy(du_busy),
    .done_valid(done_valid), .done_id(done_id), .done_tag(done_tag),
    .sched_busy(sched_busy), .perf_ops(perf_ops), .perf_busy_cycles(perf_busy_cycles)
  );

  typedef struct packed {
    logic            op;
    logic [1:0]      ce;
    logic [DW-1:0]   esc;
    logic [MVL-1:0]  mask;
    logic [VLW-1:0]  vlr;
    logic [TAGW-1:0] tag;
  } req_t;

  // nibble i of cnt/vlr belongs to requester i; nibble j of order is the j-th completion
  typedef struct packed {
    logic [15:0] cnt;
    logic [15:0] vlr;
    logic [31:0] order;
    logic [3:0]  norder;
  } vec_t;

  req_t q [NREQ][$];
  int   done_order[$];

  int   errors = 0;
  int   checks = 0;
  int   k = 0;
  bit   have_acc;
  int   acc_c0, acc_id, mptr, ucnt;
  req_t acc, lat;
  bit   rand_gate = 1'b0;
  int   last_acc_cyc, last_done_cyc, start_cnt;
  logic [TAGW-1:0] last_done_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, k, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (p + i) % NREQ;
      if (v[j[1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic req_t rnd_req(input logic [TAGW-1:0] tag, input int vlr);
    req_t r;
    r.op   = 1'($urandom_range(0, 1));
    r.ce   = 2'($urandom_range(0, 3));
    r.esc  = $urandom;
    r.mask = 16'($urandom);
    r.vlr  = 4'(vlr);
    r.tag  = tag;
    return r;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_busy();
    return have_acc && (k <= acc_c0 + int'(acc.vlr) + 4);
  endfunction

  // One clock cycle: drive, compare against the timing model, let the unit model react, advance.
  task automatic step();
    req_t r;
    bit   busy_exp, dexp;
    int   win;
    for (int i = 0; i < NREQ; i++) begin
      r = (q[i].size() != 0) ? q[i][0] : '0;
      req_valid[i] = !rst && (q[i].size() != 0) && (!rand_gate || $urandom_range(0, 3) != 0);
      req_op_div[i]              = r.op;
      req_cont_esc[i*2 +: 2]     = r.ce;
      req_op_esc[i*DW +: DW]     = r.esc;
      req_mask[i*MVL +: MVL]     = r.mask;
      req_vlr[i*VLW +: VLW]      = r.vlr;
      req_tag[i*TAGW +: TAGW]    = r.tag;
    end
    du_busy = (ucnt != 0);
    #1;
    busy_exp = have_acc && (k > acc_c0) && (k <= acc_c0 + int'(acc.vlr) + 4);
    dexp     = have_acc && (k == acc_c0 + int'(acc.vlr) + 4);
    win      = busy_exp ? -1 : rr_pick(req_valid, mptr);
    chk("req_ready", 64'(req_ready), (win < 0) ? 64'(0) : 64'(1) << win);
    chk("sched_busy", 64'(sched_busy), 64'(busy_exp));
    chk("du_start", 64'(du_start), 64'(have_acc && (k == acc_c0 + 1)));
    chk("done_valid", 64'(done_valid), 64'(dexp));
    if (dexp) begin
      chk("done_id", 64'(done_id), 64'(acc_id));
      chk("done_tag", 64'(done_tag), 64'(acc.tag));
    end
    chk("du_cfg", 64'({du_op_div, du_cont_esc, du_op_esc, du_mask, du_vlr}),
        64'({lat.op, lat.ce, lat.esc, lat.mask, lat.vlr}));
    if (done_valid) begin
      done_order.push_back(int'(done_id));
      last_done_cyc = k;
      last_done_tag = done_tag;
    end
    if (du_start) start_cnt++;
    // divide unit: busy from the edge after start for vlr+1 cycles
    if (rst) ucnt = 0;
    else if (du_start) ucnt = int'(du_vlr) + 1;
    else if (ucnt > 0) ucnt--;
    if (!rst && win >= 0) begin
      acc          = q[win].pop_front();
      acc_id       = win;
      acc_c0       = k;
      have_acc     = 1'b1;
      lat          = acc;
      mptr         = (win + 1) % NREQ;
      last_acc_cyc = k;
    end
    if (rst) begin
      have_acc = 1'b0;
      mptr     = 0;
      lat      = '0;
    end
    @(negedge clk);
    k++;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((pending() || model_busy()) && n < budget) begin
      step();
      n++;
    end
    chk("timeout", 64'(n >= budget), 64'(0));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    du_busy   = 1'b0;
    for (int i = 0; i < NREQ; i++) q[i].delete();
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    have_acc = 1'b0;
    mptr     = 0;
    lat      = '0;
    ucnt     = 0;
    done_order.delete();
    chk("rst_done_id", 64'(done_id), 64'(0));
    chk("rst_done_tag", 64'(done_tag), 64'(0));
    chk("rst_perf_ops", 64'(perf_ops), 64'(0));
    chk("rst_perf_busy", 64'(perf_busy_cycles), 64'(0));
  endtask

  vec_t vecs[6];

  initial begin
    req_t r;
    int   c0, exp_ops, exp_busy;

    rst = 1'b1; req_valid = '0; req_op_div = '0; req_cont_esc = '0; req_op_esc = '0;
    req_mask = '0; req_vlr = '0; req_tag = '0; du_busy = 1'b0;

    vecs[0] = '{cnt: 16'h0001, vlr: 16'h0003, order: 32'h0000_0000, norder: 4'd1};
    vecs[1] = '{cnt: 16'h1112, vlr: 16'h0000, order: 32'h0000_3210, norder: 4'd5};
    vecs[2] = '{cnt: 16'h1010, vlr: 16'h2050, order: 32'h0000_0031, norder: 4'd2};
    vecs[3] = '{cnt: 16'h0110, vlr: 16'h0F10, order: 32'h0000_0021, norder: 4'd2};
    vecs[4] = '{cnt: 16'h2222, vlr: 16'h4321, order: 32'h3210_3210, norder: 4'd8};
    vecs[5] = '{cnt: 16'h1001, vlr: 16'h0000, order: 32'h0000_0030, norder: 4'd2};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < NREQ; i++)
        for (int c = 0; c < int'(vecs[v].cnt[i*4 +: 4]); c++)
          q[i].push_back(rnd_req(5'(i*8 + c), int'(vecs[v].vlr[i*4 +: 4])));
      run(400);
      chk("order_len", 64'(done_order.size()), 64'(vecs[v].norder));
      for (int j = 0; j < int'(vecs[v].norder) && j < done_order.size(); j++)
        chk("order", 64'(done_order[j]), 64'(vecs[v].order[j*4 +: 4]));
    end

    // single request: latency and tag
    do_reset();
    r = rnd_req(5'd7, 3);
    r.op = 1'b0;
    q[0].push_back(r);
    start_cnt = 0;
    run(100);
    chk("single_latency", 64'(last_done_cyc - last_acc_cyc), 64'(7));
    chk("single_starts", 64'(start_cnt), 64'(1));
    chk("single_tag", 64'(last_done_tag), 64'(7));

    // wrap: pointer left at 3, then req0 and req3 compete
    do_reset();
    q[2].push_back(rnd_req(5'd1, 0));
    run(100);
    done_order.delete();
    q[0].push_back(rnd_req(5'd2, 1));
    q[3].push_back(rnd_req(5'd3, 1));
    run(100);
    chk("wrap_first", 64'(done_order.size() > 0 ? done_order[0] : -1), 64'(3));
    chk("wrap_second", 64'(done_order.size() > 1 ? done_order[1] : -1), 64'(0));

    // config forwarding, held after completion
    do_reset();
    r = '{op: 1'b1, ce: CONT_SC2, esc: 32'h10, mask: 16'hA5A5, vlr: 4'd2, tag: 5'd3};
    q[2].push_back(r);
    run(100);
    chk("cfg_cont_esc", 64'(du_cont_esc), 64'(2'b11));
    chk("cfg_op_esc", 64'(du_op_esc), 64'(32'h10));
    chk("cfg_mask", 64'(du_mask), 64'(16'hA5A5));

    // reset while RUN with the longest vector
    do_reset();
    q[0].push_back(rnd_req(5'd9, 15));
    for (int n = 0; n < 20 && q[0].size() != 0; n++) step();
    c0 = last_acc_cyc;
    for (int n = 0; n < 20 && k < c0 + 5; n++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    done_order.delete();
    repeat (3) step();
    chk("rst_no_done", 64'(done_order.size()), 64'(0));
    chk("rst_idle", 64'(sched_busy), 64'(0));
    q[0].push_back(rnd_req(5'd4, 0));
    q[1].push_back(rnd_req(5'd5, 0));
    run(100);
    chk("rst_ptr_first", 64'(done_order.size() > 0 ? done_order[0] : -1), 64'(0));

    // perf counters over two vlr=3 operations
    do_reset();
    q[0].push_back(rnd_req(5'd1, 3));
    q[1].push_back(rnd_req(5'd2, 3));
    run(100);
`ifdef VDIV_SCHED_PERF_EN
    exp_ops = 2; exp_busy = 14;
`else
    exp_ops = 0; exp_busy = 0;
`endif
    chk("perf_ops", 64'(perf_ops), 64'(exp_ops));
    chk("perf_busy_cycles", 64'(perf_busy_cycles), 64'(exp_busy));

    // randomized traffic with valids that come and go
    do_reset();
    rand_gate = 1'b1;
    for (int n = 0; n < 40; n++)
      q[$urandom_range(0, NREQ-1)].push_back(rnd_req(5'($urandom), $urandom_range(0, 15)));
    run(3000);
    rand_gate = 1'b0;
    chk("rand_count", 64'(done_order.size()), 64'(40));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
